axi_read_slave_lite: RTL
========================

AXI_READ_SLAVE_LITE -- requirements
Module: axi_read_slave_lite

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- ID_WIDTH, 4, AR/R ID width.
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, R data width; legal values 32 or 64.
- MEM_DEPTH, 256, words of internal storage.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- aclk, in, 1, single clock, all logic on rising edge.
- areset, in, 1, reset; synchronous, active-high.
- arid, in, ID_WIDTH, request ID.
- araddr, in, ADDR_WIDTH, start byte address.
- arlen, in, 8, beats minus 1.
- arsize, in, 3, log2 bytes per beat.
- arburst, in, 2, burst type: 00 FIXED, 01 INCR, 10 WRAP.
- arvalid, in, 1, AR valid.
- arready, out, 1, AR ready.
- rid, out, ID_WIDTH, echoed arid.
- rdata, out, DATA_WIDTH, beat data.
- rresp, out, 2, 00 OKAY, 10 SLVERR.
- rlast, out, 1, final beat.
- rvalid, out, 1, R valid.
- rready, in, 1, R ready.
- mem_we, in, 1, backdoor write enable.
- mem_waddr, in, log2(MEM_DEPTH), backdoor word index.
- mem_wdata, in, DATA_WIDTH, backdoor data.

Function
REQ-003 The FSM SHALL have two states: IDLE (arready=1, rvalid=0) and BURST (arready=0, rvalid=1).
REQ-004 In IDLE, arvalid&arready at edge N SHALL latch arid/araddr/arlen/arsize/arburst, enter BURST, and present beat 0 with rvalid=1 at N+1.
REQ-005 Only one burst SHALL be outstanding; no AR is accepted in BURST.
REQ-006 While rvalid=1 and rready=0, rid/rdata/rresp/rlast SHALL hold stable.
REQ-007 A beat handshake (rvalid&rready) on a non-last beat at edge M SHALL present the next beat at M+1, with no bubbles.
REQ-008 rlast SHALL be 1 exactly on beat arlen; its handshake at M SHALL return to IDLE, giving rvalid=0 and arready=1 at M+1.
REQ-009 Beat count SHALL be arlen+1 (1..256), held in an 8-bit beat counter.
REQ-010 Next beat address SHALL follow the burst type:
- FIXED: unchanged.
- INCR: addr + (1<<arsize), truncated modulo 2^ADDR_WIDTH.
- WRAP: wrap at boundary of size (arlen+1)*(1<<arsize), aligned to that size.
REQ-011 Word index SHALL be addr >> log2(DATA_WIDTH/8). rdata SHALL be the full word mem[index]; the master selects byte lanes.
REQ-012 rdata SHALL be registered when a beat is loaded. A mem_we to the same word on the same edge SHALL yield the old data.
REQ-013 mem_we SHALL write mem[mem_waddr] at the rising edge in any state.
REQ-014 rid SHALL equal the latched arid for every beat of the burst.

Reset
REQ-015 While areset=1 at an edge, the block SHALL force: state IDLE, arready=0, rvalid=0, rlast=0, rid=0, rdata=0, rresp=00.
REQ-016 arready SHALL rise on the first edge after areset deasserts.
REQ-017 Reset mid-burst SHALL abort the burst with no further beats; memory contents SHALL NOT be reset.

Configuration
REQ-018 With macro AXI_READ_SLAVE_ERR_CHECK_EN defined, a beat SHALL return rresp=10 and rdata=0 if any of the following holds:
- arsize > log2(DATA_WIDTH/8);
- arburst=11;
- WRAP with arlen not in {1,3,7,15};
- word index >= MEM_DEPTH.
A burst with such errors SHALL still return arlen+1 beats.
REQ-019 Without AXI_READ_SLAVE_ERR_CHECK_EN, rresp SHALL always be 00, and the word index SHALL be taken modulo MEM_DEPTH.

Verification
REQ-020 Backdoor mem[i]=i for all i; AR id=3, addr=0x10, len=3, size=2, INCR, rready=1 -> four consecutive beats 0x4,0x5,0x6,0x7, rid=3, rlast on beat 4 only, arready high the cycle after.
REQ-021 WRAP, addr=0x38, len=3, size=2 -> words 0xE,0xF,0xC,0xD.
REQ-022 FIXED, addr=0x20, len=2 -> three beats of 0x8; rready toggled 1,0,0,1,... -> outputs held stable during stalls, 3 beats total.
REQ-023 With ERR_CHECK_EN: addr=0x400 (index 256), len=1 -> two beats rresp=10, rdata=0. Without it -> beats return mem[0], mem[1] with rresp=00.
REQ-024 areset pulsed after beat 2 of a len=7 burst -> rvalid=0 next cycle, then arready=1; a new AR completes normally.

Source files
------------

// File: rtl/axi_read_slave_lite.sv
// AXI4 read-only slave serving bursts from an internal word memory with a backdoor write port.
// Optional AXI_READ_SLAVE_ERR_CHECK_EN: flags illegal bursts and out-of-range words with SLVERR.
module axi_read_slave_lite #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256,
    localparam int WIDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [ID_WIDTH-1:0]   rid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready,
    input  logic                  mem_we,
    input  logic [WIDX_W-1:0]     mem_waddr,
    input  logic [DATA_WIDTH-1:0] mem_wdata
);

    localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; valid never waits on ready, and payload is held while
    // valid is high and ready is low.
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t state, next_state;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  arready_q;
    logic [ID_WIDTH-1:0]   rid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  rlast_q;

    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [7:0]            beat_cnt;
    logic [7:0]            lat_len;
    logic [2:0]            lat_size;
    logic [1:0]            lat_burst;

    logic                  ar_fire;
    logic                  r_fire;
    logic                  load_beat;
    logic [ADDR_WIDTH-1:0] load_addr;
    logic [2:0]            load_size;
    logic [1:0]            load_burst;
    logic [7:0]            load_len;
    logic                  load_last;
    logic [ADDR_WIDTH-1:0] full_idx;
    logic [WIDX_W-1:0]     mem_idx;
    logic                  beat_err;

    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [2:0]            sz,
        input logic [1:0]            bt,
        input logic [7:0]            ln
    );
        logic [ADDR_WIDTH-1:0] step;
        logic [ADDR_WIDTH-1:0] inc;
        logic [ADDR_WIDTH-1:0] span;
        logic [ADDR_WIDTH-1:0] mask;
        logic [ADDR_WIDTH-1:0] res;
        step = ADDR_WIDTH'(1) << sz;
        inc  = a + step;
        // Wrap window is the whole burst footprint, aligned to its own size.
        span = ADDR_WIDTH'({1'b0, ln} + 9'd1) << sz;
        mask = span - ADDR_WIDTH'(1);
        case (bt)
            2'b00:   res = a;
            2'b10:   res = (a & ~mask) | (inc & mask);
            default: res = inc;
        endcase
        return res;
    endfunction

`ifdef AXI_READ_SLAVE_ERR_CHECK_EN
    function automatic logic burst_err(
        input logic [2:0] sz,
        input logic [1:0] bt,
        input logic [7:0] ln
    );
        logic bad_wrap_len;
        bad_wrap_len = !(ln == 8'd1 || ln == 8'd3 || ln == 8'd7 || ln == 8'd15);
        return (int'(sz) > BYTE_SHIFT) || (bt == 2'b11) || (bt == 2'b10 && bad_wrap_len);
    endfunction
`endif

    always_ff @(posedge aclk) begin
        if (areset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        ar_fire    = 1'b0;
        r_fire     = 1'b0;
        case (state)
            IDLE: begin
                if (arvalid && arready_q) begin
                    ar_fire    = 1'b1;
                    next_state = BURST;
                end
            end
            BURST: begin
                if (rready) begin
                    r_fire = 1'b1;
                    if (rlast_q) next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign load_beat = ar_fire || (r_fire && !rlast_q);

    always_comb begin
        load_addr  = '0;
        load_size  = lat_size;
        load_burst = lat_burst;
        load_len   = lat_len;
        load_last  = 1'b0;
        if (ar_fire) begin
            load_addr  = araddr;
            load_size  = arsize;
            load_burst = arburst;
            load_len   = arlen;
            load_last  = (arlen == 8'd0);
        end else begin
            load_addr  = next_addr(cur_addr, lat_size, lat_burst, lat_len);
            load_last  = ((beat_cnt + 8'd1) == lat_len);
        end
    end

    assign full_idx = load_addr >> BYTE_SHIFT;

`ifdef AXI_READ_SLAVE_ERR_CHECK_EN
    always_comb begin
        mem_idx  = WIDX_W'(full_idx);
        beat_err = burst_err(load_size, load_burst, load_len) ||
                   (full_idx >= ADDR_WIDTH'(MEM_DEPTH));
    end
`else
    always_comb begin
        mem_idx  = WIDX_W'(full_idx % ADDR_WIDTH'(MEM_DEPTH));
        beat_err = 1'b0;
    end
`endif

    // arready comes up one edge after reset releases, and on the edge a burst ends.
    always_ff @(posedge aclk) begin
        if (areset) arready_q <= 1'b0;
        else        arready_q <= (next_state == IDLE);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
            rlast_q   <= 1'b0;
            cur_addr  <= '0;
            beat_cnt  <= 8'd0;
            lat_len   <= 8'd0;
            lat_size  <= 3'd0;
            lat_burst <= 2'b00;
        end else begin
            if (ar_fire) begin
                rid_q     <= arid;
                lat_len   <= arlen;
                lat_size  <= arsize;
                lat_burst <= arburst;
            end
            if (load_beat) begin
                cur_addr <= load_addr;
                beat_cnt <= ar_fire ? 8'd0 : beat_cnt + 8'd1;
                rlast_q  <= load_last;
                rresp_q  <= beat_err ? 2'b10 : 2'b00;
                rdata_q  <= beat_err ? '0 : mem[mem_idx];
            end else if (r_fire && rlast_q) begin
                rlast_q <= 1'b0;
            end
        end
    end

    // Memory is never reset; a same-edge backdoor write is seen only by later beats.
    always_ff @(posedge aclk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign arready = arready_q;
    assign rvalid  = (state == BURST);
    assign rid     = rid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;

endmodule
